// File: rtl/frame_dump_ctrl_pkg.sv
// frame_dump_ctrl_pkg: FSM states, default frame geometry and buffer address width helper
package frame_dump_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, RD_ADDR, RD_SEND, RD_WAIT} state_t;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  function automatic int addr_w(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction
  localparam int ADDR_W_DEF = addr_w(H_RES_DEF * V_RES_DEF);
endpackage

// File: rtl/frame_dump_ctrl_uart_holdoff.sv
// frame_dump_ctrl_uart_holdoff: saturating inter-byte holdoff, cleared while the UART is busy
module frame_dump_ctrl_uart_holdoff #(
  parameter int W = 13
) (
  input  logic clk,
  input  logic resetn,
  input  logic tx_busy,
  output logic ready
);
  logic [W-1:0] cnt;
  assign ready = &cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (tx_busy) cnt <= '0;
    else if (!ready) cnt <= cnt + W'(1);
endmodule

// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: capture one CSI frame into a buffer, then dump it over UART; FRAME_DUMP_TEST_PATTERN_EN writes address bytes instead of pixels
module frame_dump_ctrl
  import frame_dump_ctrl_pkg::*;
#(
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int ADDR_W    = addr_w(H_RES * V_RES),
  parameter int HOLDOFF_W = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_we,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);
  // one spare bit so a full 2^ADDR_W frame count does not wrap to zero
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(H_RES * V_RES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state;
  logic [CNT_W-1:0] pix_cnt, rd_ptr, cap_cnt, rd_nxt;
  logic ready;
  frame_dump_ctrl_uart_holdoff #(.W(HOLDOFF_W)) u_uart_holdoff (
    .clk(clk), .resetn(resetn), .tx_busy(tx_busy), .ready(ready)
  );
  always_comb begin
    wr_en = state == CAPTURE && pix_valid && pix_cnt < TOTAL;
    wr_addr = wr_en ? pix_cnt[ADDR_W-1:0] : '0;
`ifdef FRAME_DUMP_TEST_PATTERN_EN
    wr_data = wr_en ? 8'(wr_addr) : '0;
`else
    wr_data = wr_en ? pix_data : '0;
`endif
    tx_we = state == RD_SEND && ready && !tx_busy;
    tx_data = tx_we ? rd_data : '0;
  end
  assign rd_addr = rd_ptr[ADDR_W-1:0];
  assign busy = state != IDLE;
  assign cap_cnt = pix_cnt + CNT_W'(wr_en);
  assign rd_nxt = rd_ptr + ONE;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      pix_cnt <= '0;
      rd_ptr <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) pix_cnt <= pix_cnt + ONE;
      case (state)
        IDLE: if (start) state <= WAIT_SOF;
        WAIT_SOF: if (frame_start) begin
          state <= CAPTURE;
          pix_cnt <= '0;
          rd_ptr <= '0;
        end
        CAPTURE: if (frame_end) begin
          state <= cap_cnt == '0 ? IDLE : RD_ADDR;
          done <= cap_cnt == '0;
          rd_ptr <= '0;
        end
        RD_ADDR: state <= RD_SEND;
        RD_SEND: if (tx_we) state <= RD_WAIT;
        RD_WAIT: begin
          rd_ptr <= rd_nxt;
          state <= rd_nxt == pix_cnt ? IDLE : RD_ADDR;
          done <= rd_nxt == pix_cnt;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_frame_dump_ctrl.sv
// tb_frame_dump_ctrl: table-driven and randomized frames checked against a queue-based buffer/UART model
module tb_frame_dump_ctrl;
  localparam int H = 4, V = 2, AW = 3, HW = 4;
  localparam int TOTAL = H * V, HOLD = (1 << HW) - 1;
  typedef struct {
    int npix; int pre; int coinc; int poke; int rnd; int base; int busy_fix; int exp_n;
  } vec_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  logic clk = 0, resetn = 0, start = 0, frame_start = 0, frame_end = 0, pix_valid = 0;
  logic [7:0] pix_data = 0, rd_data = 0;
  logic tx_busy, wr_en, tx_we, busy, done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, tx_data;
  frame_dump_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .HOLDOFF_W(HW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_we(tx_we), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [1 << AW];
  int busy_left = 0, busy_fix = 0;
  assign tx_busy = busy_left != 0;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
    if (tx_we) busy_left <= busy_fix != 0 ? busy_fix : int'($urandom_range(1, 20));
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end
  wr_t exp_wr[$];
  logic [7:0] exp_tx[$];
  wr_t e;
  logic [7:0] et;
  int checks = 0, errors = 0, cyc = 0, n_wr = 0, n_tx = 0, n_done = 0, tx_at_done = 0, fall_cyc = -1;
  int w0 = 0, t0 = 0, d0 = 0;
  bit prev_we = 0, prev_busy = 0, mid_dump = 0, fall_mid = 0;
  always @(negedge clk) begin
    cyc++;
    if (done) begin n_done++; tx_at_done = n_tx; mid_dump = 0; end
    if (prev_busy && !tx_busy) begin fall_cyc = cyc; fall_mid = mid_dump; end
    prev_busy = tx_busy;
    if (wr_en) begin
      n_wr++; checks++;
      if (exp_wr.size() == 0) begin
        errors++; $display("FAIL write_unexpected addr=%0d data=%02h", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          errors++;
          $display("FAIL write actual addr=%0d data=%02h required addr=%0d data=%02h", wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (tx_we) begin
      n_tx++; checks++;
      if (exp_tx.size() == 0) begin
        errors++; $display("FAIL byte_unexpected data=%02h", tx_data);
      end else begin
        et = exp_tx.pop_front();
        if (tx_data !== et) begin errors++; $display("FAIL byte actual=%02h required=%02h", tx_data, et); end
      end
      checks++;
      if (tx_busy || prev_we || wr_en) begin
        errors++; $display("FAIL handshake busy=%0b prev_we=%0b wr_en=%0b required all 0", tx_busy, prev_we, wr_en);
      end
      if (fall_cyc >= 0) begin
        checks++;
        if (fall_mid ? (cyc - fall_cyc != HOLD) : (cyc - fall_cyc < HOLD)) begin
          errors++; $display("FAIL holdoff gap=%0d required %s%0d", cyc - fall_cyc, fall_mid ? "" : ">=", HOLD);
        end
      end
      fall_cyc = -1; mid_dump = 1;
    end
    prev_we = tx_we;
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s actual=%0d required=%0d", name, act, exp); end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " wr_en"}, 32'(wr_en), 0);
    chk({tag, " tx_we"}, 32'(tx_we), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " wr_addr"}, 32'(wr_addr), 0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 0);
    chk({tag, " wr_data"}, 32'(wr_data), 0);
    chk({tag, " tx_data"}, 32'(tx_data), 0);
  endtask
  task automatic capture(input vec_t v);
    logic [7:0] d, dx;
    w0 = n_wr; t0 = n_tx; d0 = n_done; busy_fix = v.busy_fix;
    start = 1; tick(); start = 0;
    for (int i = 0; i < v.pre; i++) begin pix_valid = 1; pix_data = 8'($urandom); tick(); end
    pix_valid = 0; frame_start = 1; tick(); frame_start = 0;
    for (int i = 0; i < v.npix; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (v.poke != 0 && i == 1) begin start = 1; frame_start = 1; tick(); start = 0; frame_start = 0; end
      d = v.rnd != 0 ? 8'($urandom) : 8'(v.base + i);
      if (i < TOTAL) begin
`ifdef FRAME_DUMP_TEST_PATTERN_EN
        dx = 8'(i);
`else
        dx = d;
`endif
        exp_wr.push_back('{AW'(i), dx});
        exp_tx.push_back(dx);
      end
      pix_valid = 1; pix_data = d; frame_end = v.coinc != 0 && i == v.npix - 1;
      tick(); pix_valid = 0; frame_end = 0;
    end
    if (v.coinc == 0 || v.npix == 0) begin frame_end = 1; tick(); frame_end = 0; end
    if (v.poke != 0) begin tick(); tick(); start = 1; tick(); start = 0; end
  endtask
  task automatic finish_frame(input string tag, input vec_t v);
    for (int k = 0; k < 4000 && n_done == d0; k++) tick();
    tick();
    chk({tag, " done_count"}, n_done - d0, 1);
    chk({tag, " writes"}, n_wr - w0, v.exp_n);
    chk({tag, " bytes_at_done"}, tx_at_done - t0, v.exp_n);
    chk({tag, " busy_after"}, 32'(busy), 0);
    chk({tag, " leftover"}, exp_wr.size() + exp_tx.size(), 0);
    exp_wr.delete(); exp_tx.delete();
  endtask
  vec_t tbl[8];
  vec_t v;
  initial begin
    resetn = 0; start = 1; frame_start = 1; pix_valid = 1; pix_data = 8'h5A;
    repeat (3) tick();
    check_zero("reset");
    start = 0; frame_start = 0; pix_valid = 0;
    resetn = 1; tick();
    tbl[0] = '{5, 0, 0, 0, 0, 'hA0, 0, 5};
    tbl[1] = '{8, 2, 1, 0, 1, 0, 0, 8};
    tbl[2] = '{10, 0, 0, 0, 1, 0, 0, 8};
    tbl[3] = '{0, 1, 0, 0, 1, 0, 0, 0};
    tbl[4] = '{1, 0, 1, 0, 1, 0, 0, 1};
    tbl[5] = '{3, 3, 0, 1, 1, 0, 0, 3};
    tbl[6] = '{7, 0, 1, 0, 1, 0, 0, 7};
    tbl[7] = '{4, 0, 0, 0, 1, 0, 100, 4};
    for (int n = 0; n < 8; n++) begin
      capture(tbl[n]);
      finish_frame($sformatf("vec%0d", n), tbl[n]);
    end
    for (int n = 0; n < 12; n++) begin
      v.npix = $urandom_range(0, 11); v.pre = $urandom_range(0, 3); v.coinc = $urandom_range(0, 1);
      v.poke = v.npix >= 2 ? int'($urandom_range(0, 1)) : 0;
      v.rnd = 1; v.base = 0; v.busy_fix = 0;
      v.exp_n = v.npix < TOTAL ? v.npix : TOTAL;
      capture(v);
      finish_frame($sformatf("rnd%0d", n), v);
    end
    v = '{8, 0, 1, 0, 1, 0, 0, 8};
    capture(v);
    for (int k = 0; k < 2000 && n_tx - t0 < 3; k++) tick();
    chk("rst bytes_before", n_tx - t0, 3);
    resetn = 0; #1;
    check_zero("rst_async");
    tick(); tick();
    exp_wr.delete(); exp_tx.delete(); mid_dump = 0; fall_cyc = -1;
    resetn = 1;
    w0 = n_wr; t0 = n_tx; d0 = n_done;
    for (int k = 0; k < 300; k++) begin
      pix_valid = 1'($urandom_range(0, 1)); pix_data = 8'($urandom);
      frame_start = k % 50 == 10; frame_end = k % 50 == 40;
      tick();
    end
    pix_valid = 0; frame_start = 0; frame_end = 0;
    chk("rst writes_after", n_wr - w0, 0);
    chk("rst bytes_after", n_tx - t0, 0);
    chk("rst done_after", n_done - d0, 0);
    chk("rst busy_after", 32'(busy), 0);
    v = '{6, 1, 0, 0, 1, 0, 0, 6};
    capture(v);
    finish_frame("recover", v);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
